sipo_demux8: RTL

Serial-to-parallel deserializer for the receive end of the 8:1 bit-select multiplexer path. A serial bit stream arrives one bit per strobed cycle. A bit counter acts as the demux select and steers each bit into one position of an 8-bit word. Completed words are handed downstream over a valid/ready handshake from a single-entry output buffer. The block sits between the serial link and the byte-wide consumer logic.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_demux8_if.sv | 25 ++
 rtl/sipo_out_buf.sv | 72 +++++++
 rtl/sipo_demux8.sv | 71 +++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and output-buffer state encoding for the SIPO deserializer.
// Latency: none, this file only holds declarations.
// Backpressure: none, this file only holds declarations.
package sipo_pkg;

    localparam int SIPO_WIDTH = 8;
    localparam int CNT_W      = $clog2(SIPO_WIDTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sipo_demux8_if.sv
// Serial-in / parallel-out bundle between the link, the deserializer and the consumer.
// Latency: none, wires only.
// Backpressure: par_ready from the consumer side (master) stalls the parallel word.
interface sipo_demux8_if #(
    parameter int WIDTH = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;

    // Link/consumer side: drives the serial stream and accepts words.
    modport master (
        output ser_in, ser_valid, frame_start, par_ready,
        input  par_out, par_valid
    );

    // Deserializer side.
    modport slave (
        input  ser_in, ser_valid, frame_start, par_ready,
        output par_out, par_valid
    );
endinterface

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready holding register with sticky overrun detection.
// Latency: a word offered at edge N is valid after edge N.
// Backpressure: while full and not accepted, new words are dropped and overrun is set.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             par_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             overrun
);

    buf_state_t state_q, state_d;
    logic       load_en;
    logic       ovr_set;

    // Next-state: a completion refills the buffer when it is empty or being drained this cycle.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (load_vld) begin
                    load_en = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (par_ready) begin
                    if (load_vld) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (load_vld) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Buffer state, held word and sticky overrun (a new overrun beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            par_out <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                par_out <= load_dat;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign par_valid = (state_q == ST_FULL);

endmodule

// File: rtl/sipo_demux8.sv
// Serial-to-parallel deserializer: bit counter steers each strobed bit into the assembly word.
// Latency: final bit sampled at edge N gives par_valid and the word after edge N.
// Backpressure: one-word buffer; a word completing while the buffer is stalled is dropped (overrun).
module sipo_demux8
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    sipo_demux8_if.slave  bus,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun,
    input  logic          ovr_clr
);

    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word_d;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    pos;
    logic             last;
    logic             complete;

    // Demux: frame_start realigns so the current bit becomes index 0 of a fresh word.
    always_comb begin
        idx      = bus.frame_start ? '0 : bit_cnt;
        pos      = LSB_FIRST ? idx : (CW'(WIDTH - 1) - idx);
        base     = bus.frame_start ? '0 : asm_q;
        word_d   = base;
        word_d[pos] = bus.ser_in;
        last     = (bit_cnt == CW'(WIDTH - 1));
        complete = bus.ser_valid && !bus.frame_start && last;
    end

    // Collector register and bit counter (next-bit index).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q   <= '0;
            bit_cnt <= '0;
        end else if (bus.ser_valid) begin
            asm_q <= word_d;
            if (bus.frame_start) begin
                bit_cnt <= CW'(1);
            end else if (last) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end else if (bus.frame_start) begin
            bit_cnt <= '0;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_vld  (complete),
        .load_dat  (word_d),
        .par_ready (bus.par_ready),
        .ovr_clr   (ovr_clr),
        .par_out   (bus.par_out),
        .par_valid (bus.par_valid),
        .overrun   (overrun)
    );

endmodule
